// File: rtl/dff_pkg.sv
// dff_pkg: shared width helpers and default reset value for the dff_pipe block.
package dff_pkg;
  localparam logic [63:0] DEFAULT_RESET_VAL = '0;
  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int tap_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/dff_stage.sv
// dff_stage: one pipeline register with valid bit, async reset, enable and sync flush.
module dff_stage import dff_pkg::*; #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = DEFAULT_RESET_VAL[WIDTH-1:0]
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Flush,
  input  logic [WIDTH-1:0] D,
  input  logic             D_valid,
  output logic [WIDTH-1:0] Q,
  output logic             Q_valid
);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      Q       <= RESET_VAL;
      Q_valid <= 1'b0;
    end else if (Flush) begin
      Q       <= RESET_VAL;
      Q_valid <= 1'b0;
    end else if (En) begin
      Q       <= D;
      Q_valid <= D_valid;
    end
endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage enabled shift pipeline with valid tracking, fill count and
// optional stage tap (tap ports exist only when DFF_PIPE_TAP_EN is defined).
module dff_pipe import dff_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = DEFAULT_RESET_VAL[WIDTH-1:0]
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      En,
  input  logic                      Flush,
  input  logic [WIDTH-1:0]          D,
  input  logic                      D_valid,
  output logic [WIDTH-1:0]          Q,
  output logic [WIDTH-1:0]          Q_bar,
  output logic                      Q_valid,
  output logic [fill_w(DEPTH)-1:0]  Fill,
`ifdef DFF_PIPE_TAP_EN
  input  logic [tap_w(DEPTH)-1:0]   Tap_sel,
  output logic [WIDTH-1:0]          Tap,
`endif
  output logic                      Full
);
  localparam int FW = fill_w(DEPTH);
  localparam int TW = tap_w(DEPTH);
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic             stage_v [DEPTH];
  logic [FW-1:0]    fill_r;
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    dff_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .Clk     (Clk),
      .Reset   (Reset),
      .En      (En),
      .Flush   (Flush),
      .D       ((k == 0) ? D : stage_d[(k == 0) ? 0 : k-1]),
      .D_valid ((k == 0) ? D_valid : stage_v[(k == 0) ? 0 : k-1]),
      .Q       (stage_d[k]),
      .Q_valid (stage_v[k])
    );
  end
  // Entry and exit on the same edge cancel, so Fill tracks the popcount of valids.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) fill_r <= '0;
    else if (Flush) fill_r <= '0;
    else if (En) fill_r <= fill_r + FW'(D_valid) - FW'(stage_v[DEPTH-1]);
  assign Q       = stage_d[DEPTH-1];
  assign Q_bar   = ~Q;
  assign Q_valid = stage_v[DEPTH-1];
  assign Fill    = fill_r;
  assign Full    = (fill_r == FW'(DEPTH));
`ifdef DFF_PIPE_TAP_EN
  if (DEPTH == 1) begin : g_tap1
    logic unused_sel;
    assign unused_sel = ^Tap_sel;
    assign Tap = stage_d[0];
  end else begin : g_tapn
    assign Tap = ({1'b0, Tap_sel} < (TW+1)'(DEPTH)) ? stage_d[Tap_sel] : RESET_VAL;
  end
`endif
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed self-checking bench for dff_pipe (WIDTH=8, DEPTH=4, RESET_VAL=0).
module tb_dff_pipe;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       En = 1'b0;
  logic       Flush = 1'b0;
  logic [7:0] D = '0;
  logic       D_valid = 1'b0;
  logic [7:0] Q, Q_bar;
  logic       Q_valid, Full;
  logic [2:0] Fill;
`ifdef DFF_PIPE_TAP_EN
  logic [1:0] Tap_sel = '0;
  logic [7:0] Tap;
`endif
  int n_cmp = 0;
  int n_err = 0;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Flush(Flush), .D(D), .D_valid(D_valid),
    .Q(Q), .Q_bar(Q_bar), .Q_valid(Q_valid), .Fill(Fill),
`ifdef DFF_PIPE_TAP_EN
    .Tap_sel(Tap_sel), .Tap(Tap),
`endif
    .Full(Full)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic v);
    D = d;
    D_valid = v;
    En = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] alt_v [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    logic [2:0] alt_f [8] = '{1, 1, 2, 2, 2, 2, 2, 2};
    #2;
    check("rst_q", Q, 8'h00);
    check("rst_qbar", Q_bar, 8'hFF);
    check("rst_qv", Q_valid, 0);
    check("rst_fill", Fill, 0);
    check("rst_full", Full, 0);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hA5, 1'b1);
    check("a5_q", Q, 8'hA5);
    check("a5_full", Full, 1);
    #2 Reset = 1'b1;
    #1;
    check("async_q", Q, 8'h00);
    check("async_qbar", Q_bar, 8'hFF);
    check("async_qv", Q_valid, 0);
    check("async_fill", Fill, 0);
    #1 Reset = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(i), 1'b1);
    check("load_q", Q, 8'h01);
    check("load_qv", Q_valid, 1);
    check("load_fill", Fill, 4);
    check("load_full", Full, 1);
    En = 1'b0;
    D = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_q", Q, 8'h01);
      check("hold_fill", Fill, 4);
    end
    push(8'h99, 1'b0);
    check("drain_q", Q, 8'h02);
    check("drain_fill", Fill, 3);
    check("drain_full", Full, 0);
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 1'b1);
    check("refill_q", Q, 8'h10);
    check("refill_full", Full, 1);
    Flush = 1'b1;
    push(8'h77, 1'b1);
    Flush = 1'b0;
    check("flush_q", Q, 8'h00);
    check("flush_qv", Q_valid, 0);
    check("flush_fill", Fill, 0);
    for (int i = 0; i < 4; i++) begin
      push(8'h00, 1'b0);
      check("post_flush_q", Q, 8'h00);
      check("post_flush_qv", Q_valid, 0);
    end
    for (int i = 0; i < 8; i++) begin
      push(8'hC0 + 8'(i), alt_v[i][0]);
      check("alt_fill", Fill, alt_f[i]);
      if (i >= 3) check("alt_qv", Q_valid, alt_v[i-3]);
    end
    check("alt_q", Q, 8'hC4);
`ifdef DFF_PIPE_TAP_EN
    Flush = 1'b1;
    push(8'h00, 1'b0);
    Flush = 1'b0;
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    push(8'h44, 1'b1);
    En = 1'b0;
    Tap_sel = 2'd0; #1 check("tap0", Tap, 8'h44);
    Tap_sel = 2'd1; #1 check("tap1", Tap, 8'h33);
    Tap_sel = 2'd2; #1 check("tap2", Tap, 8'h22);
    Tap_sel = 2'd3; #1 check("tap3", Tap, 8'h11);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage (1..64).
REQ-002 Parameter DEPTH, default 4, number of register stages (1..32).
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data stage on reset or flush.
REQ-004 Clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset; assertion clears state immediately, release is synchronous to Clk.
REQ-006 En  input  1  advance enable; when low, all stages and counters hold.
REQ-007 Flush  input  1  synchronous clear of all stages, valids and fill count.
REQ-008 D  input  WIDTH  data into stage 0.
REQ-009 D_valid  input  1  qualifier for D.
REQ-010 Q  output  WIDTH  registered data of stage DEPTH-1.
REQ-011 Q_bar  output  WIDTH  bitwise inverse of Q, combinational.
REQ-012 Q_valid  output  1  registered valid of stage DEPTH-1.
REQ-013 Fill  output  FW=$clog2(DEPTH+1)  count of stages currently holding valid data.
REQ-014 Full  output  1  high when Fill == DEPTH.
REQ-015 Tap_sel  input  TW=max(1,$clog2(DEPTH))  stage index for Tap (present only with DFF_PIPE_TAP_EN).
REQ-016 Tap  output  WIDTH  data of stage Tap_sel (present only with DFF_PIPE_TAP_EN).

Function
REQ-017 On a rising edge with En=1, Flush=0: stage[0] <= D, valid[0] <= D_valid, stage[k] <= stage[k-1] and valid[k] <= valid[k-1] for k=1..DEPTH-1.
REQ-018 With En=0, Flush=0: all data, valid and Fill registers hold.
REQ-019 Latency: D sampled on edge n appears on Q after edge n+DEPTH-1, i.e. DEPTH enabled edges from D to Q; holding En low stretches latency by the number of disabled edges.
REQ-020 Flush=1 at an edge: all stages <= RESET_VAL, all valid <= 0, Fill <= 0, regardless of En; D on that edge is discarded.
REQ-021 Fill update on an enabled edge: Fill <= Fill + D_valid - valid[DEPTH-1]; simultaneous entry and exit leaves Fill unchanged.
REQ-022 Fill never exceeds DEPTH and never underflows; Fill always equals the popcount of valid[].
REQ-023 Full is combinational from the Fill register.
REQ-024 Data stages shift regardless of valid; invalid slots carry whatever D held (no bubble collapsing).
REQ-025 DEPTH=1: Q, Q_valid and Fill follow stage 0 only; TW=1 with Tap_sel ignored.

Reset
REQ-026 Reset=1 forces immediately, without Clk: all stages = RESET_VAL, Q = RESET_VAL, Q_bar = ~RESET_VAL, Q_valid = 0, Fill = 0, Full = 0.
REQ-027 Reset asserted mid-stream discards all in-flight data; first capture is the first rising edge after release with En=1.
REQ-028 Reset has priority over Flush and En.

Configuration
REQ-029 Macro DFF_PIPE_TAP_EN defined: Tap_sel/Tap ports exist; Tap = stage[Tap_sel], combinational; Tap_sel >= DEPTH returns RESET_VAL.
REQ-030 Macro DFF_PIPE_TAP_EN undefined: Tap_sel/Tap ports and tap mux are absent; all other behaviour is identical.

Structure
REQ-031 Shared package dff_pkg holds the FW/TW width functions and the default RESET_VAL constant.
REQ-032 One sub-module dff_stage: WIDTH-bit register plus valid bit with async active-high reset, enable and sync flush, instantiated DEPTH times via generate.
REQ-033 Fill counter, Full and tap mux live in dff_pipe top level.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=0, TAP_EN defined)
REQ-034 Reset pulse mid-cycle with stages full of 0xA5 -> Q=0x00, Q_bar=0xFF, Q_valid=0, Fill=0 before next Clk edge.
REQ-035 En=1, D_valid=1, D=0x01,0x02,0x03,0x04 on four edges -> Q=0x01, Q_valid=1 after 4th edge; Fill=4, Full=1.
REQ-036 Full pipe, En=0 for 3 edges, then En=1 with D_valid=0 -> Q holds 0x01 for 3 edges, then Q=0x02 and Fill=3.
REQ-037 Full pipe, Flush=1 and En=1 on same edge -> all stages 0x00, Q_valid=0, Fill=0; flushed D never reaches Q.
REQ-038 Alternating D_valid=1/0 with En=1 for 8 edges -> Fill settles at 2 and stays constant while input and output validity coincide.
REQ-039 After loading 0x11,0x22,0x33,0x44, Tap_sel=0..3 -> Tap=0x44,0x33,0x22,0x11 without a Clk edge.
